pe_array_sched: RTL and testbench

PE_ARRAY_SCHED -- requirements
Module: pe_array_sched

---
 rtl/pe_array_sched_pkg.sv | 31 +++
 rtl/pe_array_sched_delay.sv | 26 ++
 rtl/pe_array_sched.sv | 143 ++++++++++++++
 tb/tb_pe_array_sched.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/pe_array_sched_pkg.sv
// Shared types and default geometry for the PE-array pass scheduler.
// Derived widths are floored at 1 bit so degenerate geometries still elaborate.
package pe_array_sched_pkg;

    function automatic int clog2_min1(input int v);
        return (v > 1) ? $clog2(v) : 1;
    endfunction

    localparam int ROWS_DEF     = 64;
    localparam int COLS_DEF     = 64;
    localparam int WCOUNT_DEF   = 4;
    localparam int NPE_DEF      = 16;
    localparam int MEM_LAT_DEF  = 1;
    localparam int PE_FLUSH_DEF = 3;

    localparam int PASSES_DEF = ROWS_DEF / NPE_DEF;
    localparam int BEATS_DEF  = COLS_DEF / WCOUNT_DEF;
    localparam int AW_DEF     = clog2_min1(PASSES_DEF * BEATS_DEF);
    localparam int PW_DEF     = clog2_min1(PASSES_DEF);
    localparam int BW_DEF     = clog2_min1(BEATS_DEF);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_GUARD,
        S_FEED,
        S_FLUSH,
        S_RESULT
    } state_e;

endpackage

// File: rtl/pe_array_sched_delay.sv
// Fixed-depth shift register that aligns the read strobe and beat index
// with the data returning from the matrix memory.
module sched_delay_line #(
    parameter int DEPTH = 1,
    parameter int W     = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] d_i,
    output logic [W-1:0] q_o
);

    logic [DEPTH-1:0][W-1:0] pipe_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            pipe_q <= '0;
        end else begin
            pipe_q[0] <= d_i;
            for (int i = 1; i < DEPTH; i++) pipe_q[i] <= pipe_q[i-1];
        end
    end

    assign q_o = pipe_q[DEPTH-1];

endmodule

// File: rtl/pe_array_sched.sv
// Sequences one matrix-vector job as PASSES passes of clear, feed, flush and
// result hand-off across a broadcast-controlled PE array.
module pe_array_sched
    import pe_array_sched_pkg::*;
#(
    parameter int ROWS     = ROWS_DEF,
    parameter int COLS     = COLS_DEF,
    parameter int WCOUNT   = WCOUNT_DEF,
    parameter int NPE      = NPE_DEF,
    parameter int MEM_LAT  = MEM_LAT_DEF,
    parameter int PE_FLUSH = PE_FLUSH_DEF,
    localparam int PASSES  = ROWS / NPE,
    localparam int BEATS   = COLS / WCOUNT,
    localparam int AW      = clog2_min1(PASSES * BEATS),
    localparam int PW      = clog2_min1(PASSES),
    localparam int BW      = clog2_min1(BEATS)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    output logic          ready,
    output logic          busy,
    output logic          done,
    output logic          m_rd_en,
    output logic [AW-1:0] m_addr,
    output logic [BW-1:0] x_sel,
    output logic          pe_en,
    output logic          pe_clr,
    output logic          x_zero,
    output logic          res_valid,
    output logic [PW-1:0] res_pass,
    input  logic          res_ready
);

    // FLUSH first waits out the in-flight delayed beats, then runs the zero-data cycles.
    localparam int FW = clog2_min1(MEM_LAT + PE_FLUSH);

    state_e        state_q, state_d;
    logic [PW-1:0] pass_q, pass_d;
    logic [BW-1:0] beat_q, beat_d;
    logic [FW-1:0] fcnt_q, fcnt_d;
    logic          done_q, done_d;
    logic          dly_en;
    logic [BW-1:0] dly_beat;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            pass_q  <= '0;
            beat_q  <= '0;
            fcnt_q  <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pass_q  <= pass_d;
            beat_q  <= beat_d;
            fcnt_q  <= fcnt_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        pass_d    = pass_q;
        beat_d    = beat_q;
        fcnt_d    = fcnt_q;
        done_d    = 1'b0;
        pe_clr    = 1'b0;
        m_rd_en   = 1'b0;
        m_addr    = '0;
        x_zero    = 1'b0;
        res_valid = 1'b0;
        res_pass  = '0;
        case (state_q)
            S_IDLE: begin
                // The done cycle still sits in IDLE but must not accept a new job.
                if (start && !done_q) begin
                    pass_d  = '0;
                    state_d = S_CLEAR;
                end
            end
            S_CLEAR: begin
                pe_clr  = 1'b1;
                state_d = S_GUARD;
            end
            S_GUARD: begin
                beat_d  = '0;
                state_d = S_FEED;
            end
            S_FEED: begin
                m_rd_en = 1'b1;
                m_addr  = AW'(pass_q) * AW'(BEATS) + AW'(beat_q);
                if (beat_q == BW'(BEATS - 1)) begin
                    beat_d  = '0;
                    fcnt_d  = '0;
                    state_d = S_FLUSH;
                end else begin
                    beat_d = beat_q + BW'(1);
                end
            end
            S_FLUSH: begin
                x_zero = (fcnt_q >= FW'(MEM_LAT));
                if (fcnt_q == FW'(MEM_LAT + PE_FLUSH - 1)) begin
                    fcnt_d  = '0;
                    state_d = S_RESULT;
                end else begin
                    fcnt_d = fcnt_q + FW'(1);
                end
            end
            S_RESULT: begin
                res_valid = 1'b1;
                res_pass  = pass_q;
                if (res_ready) begin
                    if (pass_q == PW'(PASSES - 1)) begin
                        done_d  = 1'b1;
                        state_d = S_IDLE;
                    end else begin
                        pass_d  = pass_q + PW'(1);
                        state_d = S_CLEAR;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    sched_delay_line #(
        .DEPTH (MEM_LAT),
        .W     (BW + 1)
    ) u_dly (
        .clk (clk),
        .rst (rst),
        .d_i ({m_rd_en, beat_q}),
        .q_o ({dly_en, dly_beat})
    );

    assign ready = (state_q == S_IDLE) && !done_q;
    assign busy  = ~ready;
    assign done  = done_q;
    assign pe_en = dly_en | x_zero;
    assign x_sel = dly_beat;

endmodule

// File: tb/tb_pe_array_sched.sv
// Randomized and directed bench for pe_array_sched: a pass-timeline reference
// model feeds scoreboard queues that a negedge monitor drains against the DUT.
module tb_pe_array_sched;

    localparam int PASSES = 4;
    localparam int BEATS  = 16;
    localparam int ML     = 1;
    localparam int PF     = 3;
    localparam int LAT    = 22;
    localparam int LAT3   = 24;

    logic       clk = 1'b0;
    logic       rst, start, res_ready;
    logic       ready, busy, done, m_rd_en, pe_en, pe_clr, x_zero, res_valid;
    logic [5:0] m_addr;
    logic [3:0] x_sel;
    logic [1:0] res_pass;

    logic       rst3, start3;
    logic       ready3, busy3, done3, m_rd_en3, pe_en3, pe_clr3, x_zero3, res_valid3;
    logic [5:0] m_addr3;
    logic [3:0] x_sel3;
    logic [1:0] res_pass3;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    pe_array_sched dut (
        .clk(clk), .rst(rst), .start(start), .ready(ready), .busy(busy), .done(done),
        .m_rd_en(m_rd_en), .m_addr(m_addr), .x_sel(x_sel), .pe_en(pe_en), .pe_clr(pe_clr),
        .x_zero(x_zero), .res_valid(res_valid), .res_pass(res_pass), .res_ready(res_ready)
    );

    pe_array_sched #(.MEM_LAT(3)) dut3 (
        .clk(clk), .rst(rst3), .start(start3), .ready(ready3), .busy(busy3), .done(done3),
        .m_rd_en(m_rd_en3), .m_addr(m_addr3), .x_sel(x_sel3), .pe_en(pe_en3), .pe_clr(pe_clr3),
        .x_zero(x_zero3), .res_valid(res_valid3), .res_pass(res_pass3), .res_ready(1'b1)
    );

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual %0h, required %0h", nm, act, exp);
        end
    endtask

    // Reference model: job position expressed as (pass, cycle offset since CLEAR).
    bit m_idle = 1'b1, m_done = 1'b0, m_inres = 1'b0, m_rst_prev = 1'b0, mon_en = 1'b0;
    int m_pass = 0, m_off = 0;
    int exp_addr_q[$];
    int exp_res_q[$];

    initial forever begin
        @(posedge clk);
        m_rst_prev = rst;
        if (rst) begin
            m_idle = 1'b1; m_done = 1'b0; m_inres = 1'b0; m_pass = 0; m_off = 0;
            exp_addr_q.delete(); exp_res_q.delete();
            mon_en = 1'b1;
        end else if (m_done) begin
            m_done = 1'b0;
        end else if (m_idle) begin
            if (start) begin m_idle = 1'b0; m_pass = 0; m_off = 0; end
        end else if (m_inres) begin
            if (res_ready) begin
                m_inres = 1'b0;
                if (m_pass == PASSES - 1) begin m_idle = 1'b1; m_done = 1'b1; end
                else begin m_pass++; m_off = 0; end
            end
        end else begin
            m_off++;
            if (m_off == LAT) begin m_inres = 1'b1; exp_res_q.push_back(m_pass); end
        end
        if (!m_idle && !m_inres && m_off >= 2 && m_off < 2 + BEATS)
            exp_addr_q.push_back(m_pass * BEATS + m_off - 2);
    end

    initial begin
        bit e_rdy, e_clr, e_rd, e_xz, e_pe, prev_rv;
        int cyc, clr_cyc, dcnt, fcnt;
        prev_rv = 1'b0; cyc = 0; clr_cyc = 0; dcnt = 0; fcnt = 0;
        forever begin
            @(negedge clk);
            cyc++;
            if (mon_en) begin
                e_rdy = m_idle && !m_done;
                e_clr = !m_idle && !m_inres && m_off == 0;
                e_rd  = !m_idle && !m_inres && m_off >= 2 && m_off < 2 + BEATS;
                e_xz  = !m_idle && !m_inres && m_off >= 2 + BEATS + ML && m_off < LAT;
                e_pe  = e_xz || (!m_idle && !m_inres && m_off >= 2 + ML && m_off < 2 + BEATS + ML);
                check("ctl", {ready, busy, done, pe_clr, m_rd_en, pe_en, x_zero, res_valid},
                      {e_rdy, !e_rdy, m_done, e_clr, e_rd, e_pe, e_xz, m_inres});
                check("res_pass", res_pass, m_inres ? m_pass : 0);
                if (m_rst_prev)
                    check("rst_vals", {ready, busy, done, m_rd_en, m_addr, x_sel, pe_en,
                                       pe_clr, x_zero, res_valid, res_pass}, {1'b1, 19'd0});
                if (m_rd_en) begin
                    if (exp_addr_q.size() == 0) check("addr_unexpected", 1, 0);
                    else check("m_addr", m_addr, exp_addr_q.pop_front());
                end
                if (e_pe && !e_xz) check("x_sel", x_sel, (m_off - 2 - ML) & 15);
                if (pe_clr) begin clr_cyc = cyc; dcnt = 0; fcnt = 0; end
                if (pe_en && !x_zero) dcnt++;
                if (x_zero) fcnt++;
                if (res_valid && !prev_rv) begin
                    if (exp_res_q.size() == 0) check("res_unexpected", 1, 0);
                    else check("res_pass_sb", res_pass, exp_res_q.pop_front());
                    check("latency", cyc - clr_cyc, LAT);
                    check("pe_data_cnt", dcnt, BEATS);
                    check("pe_flush_cnt", fcnt, PF);
                end
                prev_rv = res_valid;
            end
        end
    end

    // MEM_LAT=3 instance: alignment and per-pass latency only.
    bit mon3_en = 1'b0;
    int rv3_cnt = 0, done3_cnt = 0;
    initial begin
        int cyc3, clr3, rd_rise3;
        bit prv_rd3, prv_pe3, prv_rv3;
        bit [3:0] rd_hist;
        cyc3 = 0; clr3 = 0; rd_rise3 = 0; prv_rd3 = 0; prv_pe3 = 0; prv_rv3 = 0; rd_hist = '0;
        forever begin
            @(negedge clk);
            cyc3++;
            if (mon3_en) begin
                if (pe_clr3) clr3 = cyc3;
                if (m_rd_en3 && !prv_rd3) rd_rise3 = cyc3;
                if (pe_en3 && !prv_pe3) check("lag3", cyc3 - rd_rise3, 3);
                check("pe3_align", pe_en3 & ~x_zero3, rd_hist[2]);
                if (res_valid3 && !prv_rv3) begin
                    check("latency3", cyc3 - clr3, LAT3);
                    rv3_cnt++;
                end
                if (done3) done3_cnt++;
                rd_hist = {rd_hist[2:0], m_rd_en3};
                prv_rd3 = m_rd_en3; prv_pe3 = pe_en3; prv_rv3 = res_valid3;
            end
        end
    end

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_idle(input string nm);
        bit ok = 1'b0;
        for (int i = 0; i < 600; i++) begin
            @(negedge clk);
            if (ready) begin ok = 1'b1; break; end
        end
        check({nm, "_reach_idle"}, ok, 1);
    endtask

    task automatic wait_addr(input int a, input string nm);
        bit ok = 1'b0;
        for (int i = 0; i < 600; i++) begin
            @(negedge clk);
            if (m_rd_en && m_addr == 6'(a)) begin ok = 1'b1; break; end
        end
        check({nm, "_reach_addr"}, ok, 1);
    endtask

    task automatic wait_res(input int p, input string nm);
        bit ok = 1'b0;
        for (int i = 0; i < 600; i++) begin
            @(negedge clk);
            if (res_valid && res_pass == 2'(p)) begin ok = 1'b1; break; end
        end
        check({nm, "_reach_res"}, ok, 1);
    endtask

    initial begin
        rst = 1'b1; rst3 = 1'b1; start = 1'b0; start3 = 1'b0; res_ready = 1'b1;
        repeat (2) @(negedge clk);
        // Full job straight out of reset on both instances, consumer always ready.
        rst = 1'b0; rst3 = 1'b0; mon3_en = 1'b1;
        start = 1'b1; start3 = 1'b1;
        @(negedge clk);
        start = 1'b0; start3 = 1'b0;
        wait_idle("s1");

        // Consumer stalls pass 1 for 10 cycles.
        pulse_start();
        wait_res(1, "s2");
        res_ready = 1'b0;
        repeat (10) @(negedge clk);
        res_ready = 1'b1;
        wait_idle("s2");

        // Stray start during FEED of pass 2.
        pulse_start();
        wait_addr(36, "s3");
        pulse_start();
        wait_idle("s3");

        // Reset at beat 7 of pass 1, then a fresh job.
        pulse_start();
        wait_addr(23, "s4");
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        pulse_start();
        wait_idle("s4");

        // Random consumer back-pressure, stray starts and one mid-job reset.
        for (int j = 0; j < 6; j++) begin
            bit fin;
            fin = 1'b0;
            repeat ($urandom_range(0, 3)) @(negedge clk);
            pulse_start();
            for (int k = 0; k < 1000; k++) begin
                res_ready = ($urandom_range(0, 3) != 0);
                start     = ($urandom_range(0, 15) == 0);
                rst       = (j == 3 && k == 40);
                @(negedge clk);
                if (ready) begin fin = 1'b1; break; end
            end
            start = 1'b0; rst = 1'b0; res_ready = 1'b1;
            check("rand_job_end", fin, 1);
        end

        repeat (3) @(negedge clk);
        check("addr_q_drained", exp_addr_q.size(), 0);
        check("res_q_drained", exp_res_q.size(), 0);
        check("rv3_count", rv3_cnt, PASSES);
        check("done3_count", done3_cnt, 1);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
